// File: rtl/kf_iter_sequencer.sv
// Step sequencer for the fixed-point Kalman filter: launches NSTG stages in order per iteration,
// strobes write-back, counts iterations. Optional per-stage WAIT timeout under KF_SEQ_TIMEOUT_EN.
module kf_iter_sequencer #(
   parameter int NSTG   = 5,
   parameter int ITW    = 8,
   parameter int TO_CYC = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            go,
   input  logic            abort,
   input  logic [ITW-1:0]  cfg_iters,
   input  logic [NSTG-1:0] stg_done,
   output logic [NSTG-1:0] stg_start,
   output logic            fb_we,
   output logic            busy,
   output logic [ITW-1:0]  iter_idx,
   output logic            done,
   output logic            err,
   output logic [2:0]      err_stage
);

   localparam int KW = (NSTG > 1) ? $clog2(NSTG) : 1;
   localparam logic [NSTG-1:0] ONE = NSTG'(1);

   typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_FEED, S_FIN, S_ERR} state_t;

   state_t         st;
   logic [KW-1:0]  k;
   logic [ITW-1:0] iters;
   logic           last_iter;

   // Widened so iters = 2^ITW-1 compares correctly without wrap.
   assign last_iter = ({1'b0, iter_idx} + 1'b1) >= {1'b0, iters};

`ifdef KF_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TO_CYC + 1);
   logic [TW-1:0] to_cnt;
`else
   assign err       = 1'b0;
   assign err_stage = 3'd0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st        <= S_IDLE;
         k         <= '0;
         iters     <= '0;
         iter_idx  <= '0;
         stg_start <= '0;
         fb_we     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef KF_SEQ_TIMEOUT_EN
         to_cnt    <= '0;
         err       <= 1'b0;
         err_stage <= 3'd0;
`endif
      end else begin
         stg_start <= '0;
         fb_we     <= 1'b0;
         done      <= 1'b0;
         if (abort) begin
            st   <= S_IDLE;
            busy <= 1'b0;
         end else begin
            case (st)
               S_IDLE: if (go) begin
                  iters     <= (cfg_iters == '0) ? ITW'(1) : cfg_iters;
                  iter_idx  <= '0;
                  k         <= '0;
                  stg_start <= ONE;
                  busy      <= 1'b1;
                  st        <= S_LAUNCH;
`ifdef KF_SEQ_TIMEOUT_EN
                  err       <= 1'b0;
`endif
               end
               S_LAUNCH: begin
`ifdef KF_SEQ_TIMEOUT_EN
                  to_cnt <= '0;
`endif
                  st <= S_WAIT;
               end
               S_WAIT: begin
                  // A done in the same cycle as the timeout limit still advances.
                  if (stg_done[k]) begin
                     if (k == KW'(NSTG - 1)) begin
                        fb_we <= 1'b1;
                        st    <= S_FEED;
                     end else begin
                        k         <= k + 1'b1;
                        stg_start <= ONE << (k + 1'b1);
                        st        <= S_LAUNCH;
                     end
                  end
`ifdef KF_SEQ_TIMEOUT_EN
                  else if (to_cnt == TW'(TO_CYC - 1)) begin
                     err       <= 1'b1;
                     err_stage <= 3'(k);
                     done      <= 1'b1;
                     st        <= S_ERR;
                  end else begin
                     to_cnt <= to_cnt + 1'b1;
                  end
`endif
               end
               S_FEED: begin
                  if (!last_iter) begin
                     iter_idx  <= iter_idx + 1'b1;
                     k         <= '0;
                     stg_start <= ONE;
                     st        <= S_LAUNCH;
                  end else begin
                     done <= 1'b1;
                     st   <= S_FIN;
                  end
               end
               S_FIN, S_ERR: begin
                  busy <= 1'b0;
                  st   <= S_IDLE;
               end
               default: begin
                  busy <= 1'b0;
                  st   <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_kf_iter_sequencer.sv
// Randomized bench for kf_iter_sequencer: stage responder model plus event-level timing/order model.
module tb_kf_iter_sequencer;
   localparam int NSTG = 5, ITW = 8, TO_CYC = 64;

   logic clk = 0, rst_n = 0, go = 0, abort = 0;
   logic [ITW-1:0]  cfg_iters = '0;
   logic [NSTG-1:0] stg_done = '0;
   logic [NSTG-1:0] stg_start;
   logic            fb_we, busy, done, err;
   logic [ITW-1:0]  iter_idx;
   logic [2:0]      err_stage;

   kf_iter_sequencer #(.NSTG(NSTG), .ITW(ITW), .TO_CYC(TO_CYC)) dut (
      .clk(clk), .rst_n(rst_n), .go(go), .abort(abort), .cfg_iters(cfg_iters),
      .stg_done(stg_done), .stg_start(stg_start), .fb_we(fb_we), .busy(busy),
      .iter_idx(iter_idx), .done(done), .err(err), .err_stage(err_stage));

   always #5 clk = ~clk;

   int n_tst = 0, n_fail = 0, cyc = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tst++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   initial forever begin @(posedge clk); cyc++; end

   // Stage responder: each started stage answers lat cycles later; optional spurious pulses.
   int pend[NSTG];
   int cur = -1, last_done_cyc = 0, lat_lo = 8, lat_hi = 8;
   bit hang_last = 0, spur_en = 0;
   initial forever begin
      @(posedge clk); #1;
      stg_done = '0;
      for (int s = 0; s < NSTG; s++)
         if (pend[s] > 0) begin
            pend[s]--;
            if (pend[s] == 0) begin
               stg_done[s] = 1'b1;
               if (s == cur) last_done_cyc = cyc;
            end
         end
      for (int s = 0; s < NSTG; s++)
         if (stg_start[s] === 1'b1) begin
            cur = s;
            if (!(hang_last && s == NSTG - 1)) pend[s] = int'($urandom_range(lat_hi, lat_lo));
         end
      if (spur_en && $urandom_range(3, 0) == 0) begin
         int s = int'($urandom_range(NSTG - 1, 0));
         if (s != cur) stg_done[s] = 1'b1;
      end
   end

   // Event monitor: expected timing derived from the handshake rules.
   int st_q[$];
   int fb_cnt = 0, done_cnt = 0, go_cyc = 0, last_fb_cyc = 0, last_st_cyc = 0, done_cyc = 0;
   bit run_first = 0, busy_chk = 0;
   initial forever begin
      @(negedge clk);
      if (busy_chk) begin chk("busy_after_done", 32'(busy), 0); busy_chk = 0; end
      if (stg_start !== '0) begin
         int idx = 0, exp_c;
         chk("start_onehot", 32'($onehot(stg_start)), 1);
         for (int s = 0; s < NSTG; s++) if (stg_start[s]) idx = s;
         st_q.push_back(idx);
         if (run_first) exp_c = go_cyc + 1;
         else if (idx == 0) exp_c = last_done_cyc + 2;
         else exp_c = last_done_cyc + 1;
         chk("start_cyc", 32'(cyc), 32'(exp_c));
         chk("start_iter", 32'(iter_idx), 32'((st_q.size() - 1) / NSTG));
         run_first = 0;
         last_st_cyc = cyc;
      end
      if (fb_we) begin
         chk("fb_iter", 32'(iter_idx), 32'(fb_cnt));
         chk("fb_cyc", 32'(cyc), 32'(last_done_cyc + 1));
         fb_cnt++;
         last_fb_cyc = cyc;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
         busy_chk = 1;
         chk("busy_at_done", 32'(busy), 1);
         if (!err) chk("done_cyc", 32'(cyc), 32'(last_fb_cyc + 1));
      end
   end

   task automatic start_go(input int n);
      st_q.delete(); fb_cnt = 0; done_cnt = 0;
      @(posedge clk); #1;
      cfg_iters = ITW'(n); go = 1; go_cyc = cyc; run_first = 1;
      @(posedge clk); #1;
      go = 0; cfg_iters = ITW'($urandom);
   endtask

   task automatic wait_done(input int budget, input bit spam);
      for (int i = 0; i < budget && done_cnt == 0; i++) begin
         @(posedge clk); #1;
         go = (spam && busy && ($urandom_range(4, 0) == 0));
      end
      go = 0;
      chk("run_finished", 32'(done_cnt), 1);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic do_run(input int n, input bit spam);
      int en = (n == 0) ? 1 : n;
      start_go(n);
      wait_done(20000, spam);
      chk("n_starts", 32'(st_q.size()), 32'(en * NSTG));
      foreach (st_q[i]) chk("start_order", 32'(st_q[i]), 32'(i % NSTG));
      chk("n_fb", 32'(fb_cnt), 32'(en));
      chk("n_done", 32'(done_cnt), 1);
      chk("iter_last", 32'(iter_idx), 32'(en - 1));
      chk("err_clear", 32'(err), 0);
   endtask

   task automatic wait_starts(input int n);
      for (int i = 0; i < 2000 && st_q.size() < n; i++) @(posedge clk);
      #1;
      chk("reach_starts", 32'(st_q.size()), 32'(n));
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_start", 32'(stg_start), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_fb", 32'(fb_we), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_iter", 32'(iter_idx), 0);
      chk("rst_err", {28'(err), err_stage}, 0);
      rst_n = 1;

      do_run(3, 0);
      do_run(0, 0);

      spur_en = 1; lat_lo = 1; lat_hi = 12;
      do_run(3, 1);
      for (int r = 0; r < 4; r++) do_run(int'($urandom_range(4, 1)), 1);
      spur_en = 0;

      lat_lo = 1; lat_hi = 1;
      do_run(255, 0);

      // Abort during WAIT of stage 2, iteration 1.
      lat_lo = 6; lat_hi = 10;
      start_go(3);
      wait_starts(NSTG + 3);
      @(posedge clk); #1;
      abort = 1;
      @(posedge clk); #1;
      abort = 0;
      chk("abort_busy", 32'(busy), 0);
      repeat (20) @(posedge clk);
      #1;
      chk("abort_starts", 32'(st_q.size()), 32'(NSTG + 3));
      chk("abort_fb", 32'(fb_cnt), 1);
      chk("abort_done", 32'(done_cnt), 0);
      do_run(2, 0);

`ifdef KF_SEQ_TIMEOUT_EN
      lat_lo = 2; lat_hi = 4; hang_last = 1;
      start_go(2);
      wait_done(1000, 0);
      chk("to_err", 32'(err), 1);
      chk("to_stage", 32'(err_stage), 4);
      chk("to_fb", 32'(fb_cnt), 0);
      chk("to_starts", 32'(st_q.size()), 32'(NSTG));
      chk("to_cyc", 32'(done_cyc), 32'(last_st_cyc + TO_CYC + 1));
      hang_last = 0;
      do_run(1, 0);
`endif

      // Asynchronous reset mid-WAIT.
      lat_lo = 8; lat_hi = 8;
      start_go(2);
      wait_starts(2);
      @(posedge clk); #2;
      rst_n = 0;
      #1;
      chk("arst_start", 32'(stg_start), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_iter", 32'(iter_idx), 0);
      chk("arst_err", {28'(err), err_stage}, 0);
      for (int s = 0; s < NSTG; s++) pend[s] = 0;
      cur = -1;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1;
      chk("arst_no_done", 32'(done_cnt), 0);
      do_run(2, 0);

      $display("[TB] %0d tests run, %0d failed", n_tst, n_fail);
      $finish;
   end
endmodule
